rv32i_ctrl: RTL and testbench

RV32I_CTRL -- requirements
Module: rv32i_ctrl

---
 rtl/rv32i_pkg.sv | 47 ++++
 rtl/rv32i_bus_timer.sv | 44 ++++
 rtl/rv32i_ctrl.sv | 154 +++++++++++++++
 tb/tb_rv32i_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared FSM states, opcode[6:2] constants and trap causes for
//                the RV32I control unit, decoder and datapath.
//  Revision    : 1.0
// ============================================================================
package rv32i_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [4:0] c_OP_LOAD   = 5'b00000;
    localparam logic [4:0] c_OP_STORE  = 5'b01000;
    localparam logic [4:0] c_OP_BRANCH = 5'b11000;
    localparam logic [4:0] c_OP_JAL    = 5'b11011;
    localparam logic [4:0] c_OP_JALR   = 5'b11001;
    localparam logic [4:0] c_OP_OP     = 5'b01100;
    localparam logic [4:0] c_OP_OPIMM  = 5'b00100;
    localparam logic [4:0] c_OP_LUI    = 5'b01101;
    localparam logic [4:0] c_OP_AUIPC  = 5'b00101;

    localparam logic [1:0] c_CAUSE_NONE     = 2'b00;
    localparam logic [1:0] c_CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] c_CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] c_CAUSE_MISALIGN = 2'b11;

    // Only 32-bit encodings of the nine supported major opcodes are legal.
    function automatic logic is_legal(input logic [6:0] opc7);
        logic w_known;
        w_known = 1'b0;
        case (opc7[6:2])
            c_OP_LOAD, c_OP_STORE, c_OP_BRANCH, c_OP_JAL, c_OP_JALR,
            c_OP_OP, c_OP_OPIMM, c_OP_LUI, c_OP_AUIPC: w_known = 1'b1;
            default: w_known = 1'b0;
        endcase
        return (opc7[1:0] == 2'b11) && w_known;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_bus_timer
//  Description : Memory wait counter; flags expiry after BUS_TIMEOUT cycles
//                without ack. An ack in the final cycle takes precedence.
//  Revision    : 1.0
// ============================================================================
module rv32i_bus_timer #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ack,
    output logic expired
);

    generate
        if (BUS_TIMEOUT > 0) begin : g_timer
            localparam int c_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
            localparam logic [c_W-1:0] c_LIMIT = c_W'(BUS_TIMEOUT - 1);

            logic [c_W-1:0] r_count;

            // Count holds the number of already-waited cycles, so the current
            // cycle is the last allowed one when it equals BUS_TIMEOUT-1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (!active || ack) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign expired = active && !ack && (r_count == c_LIMIT);
        end else begin : g_no_timer
            assign expired = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rv32i_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_ctrl
//  Description : Multi-cycle RV32I control FSM: fetch, decode, execute,
//                memory, write-back and an absorbing trap state.
//  Revision    : 1.0
// ============================================================================
module rv32i_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    input  logic [31:0] target,
    output logic        rf_we,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_instret;
    logic [1:0]  r_cause;

    logic [4:0]  w_opcode;
    logic        w_is_jump;
    logic        w_misaligned;
    logic [31:0] w_pc_plus4;
    logic        w_bus_active;
    logic        w_bus_ack;
    logic        w_timeout;

    assign w_opcode     = r_ir[6:2];
    assign w_is_jump    = (w_opcode == c_OP_JAL) || (w_opcode == c_OP_JALR);
    assign w_misaligned = (target[1:0] != 2'b00);
    assign w_pc_plus4   = r_pc + 32'd4;

    assign w_bus_active = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_bus_ack    = ((r_state == S_FETCH) && imem_ack) ||
                          ((r_state == S_MEM)   && dmem_ack);

    rv32i_bus_timer #(
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) u_bus_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (w_bus_active),
        .ack     (w_bus_ack),
        .expired (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_instret <= 32'd0;
            r_cause   <= c_CAUSE_NONE;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        if (is_legal(imem_rdata[6:0])) begin
                            r_ir    <= imem_rdata;
                            r_state <= S_DECODE;
                        end else begin
                            r_cause <= c_CAUSE_ILLEGAL;
                            r_state <= S_TRAP;
                        end
                    end else if (w_timeout) begin
                        r_cause <= c_CAUSE_TIMEOUT;
                        r_state <= S_TRAP;
                    end
                end
                S_DECODE: r_state <= S_EXEC;
                S_EXEC: begin
                    case (w_opcode)
                        c_OP_LOAD, c_OP_STORE: r_state <= S_MEM;
                        c_OP_BRANCH: begin
                            if (branch_taken && w_misaligned) begin
                                r_cause <= c_CAUSE_MISALIGN;
                                r_state <= S_TRAP;
                            end else begin
                                r_pc      <= branch_taken ? target : w_pc_plus4;
                                r_instret <= r_instret + 32'd1;
                                r_state   <= S_FETCH;
                            end
                        end
                        c_OP_JAL, c_OP_JALR: begin
                            if (w_misaligned) begin
                                r_cause <= c_CAUSE_MISALIGN;
                                r_state <= S_TRAP;
                            end else begin
                                r_pc    <= target;
                                r_state <= S_WB;
                            end
                        end
                        default: r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (w_opcode == c_OP_STORE) begin
                            r_pc      <= w_pc_plus4;
                            r_instret <= r_instret + 32'd1;
                            r_state   <= S_FETCH;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (w_timeout) begin
                        r_cause <= c_CAUSE_TIMEOUT;
                        r_state <= S_TRAP;
                    end
                end
                S_WB: begin
                    if (!w_is_jump) begin
                        r_pc <= w_pc_plus4;
                    end
                    r_instret <= r_instret + 32'd1;
                    r_state   <= S_FETCH;
                end
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_TRAP;
            endcase
        end
    end

    // Strobes come from the state register only; rst_n gating drops them
    // the moment reset asserts, even while the FSM sits in FETCH.
    assign imem_req   = rst_n && (r_state == S_FETCH);
    assign dmem_req   = rst_n && (r_state == S_MEM);
    assign dmem_we    = rst_n && (r_state == S_MEM) && (w_opcode == c_OP_STORE);
    assign rf_we      = rst_n && (r_state == S_WB);
    assign trap       = (r_state == S_TRAP);
    assign trap_cause = r_cause;
    assign pc         = r_pc;
    assign ir         = r_ir;
    assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_ctrl
//  Description : Scoreboard bench for rv32i_ctrl with a wait-state memory model.
//  Revision    : 1.0
// ============================================================================
module tb_rv32i_ctrl;

    localparam logic [31:0] c_ADDI = 32'h0050_0093;
    localparam logic [31:0] c_LW   = 32'h0000_A103;
    localparam logic [31:0] c_SW   = 32'h0020_A023;
    localparam logic [31:0] c_BEQ  = 32'h0000_0063;
    localparam logic [31:0] c_JAL  = 32'h0000_006F;
    localparam logic [31:0] c_FENCE = 32'h0000_000F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [31:0] imem_rdata, pc, ir, target, instret;
    logic        branch_taken, rf_we, trap;
    logic [1:0]  trap_cause;

    rv32i_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .BUS_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .ir           (ir),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .branch_taken (branch_taken),
        .target       (target),
        .rf_we        (rf_we),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    // Memory model: ack after a configurable number of wait cycles.
    int          imem_wait = 0, dmem_wait = 0;
    logic        imem_never = 1'b0, extra_iack = 1'b0, extra_dack = 1'b0;
    int          i_cnt, d_cnt, prog_idx;
    int          prog_len = 1;
    logic [31:0] prog [2];

    assign imem_ack   = extra_iack | (imem_req & !imem_never & (i_cnt == imem_wait));
    assign dmem_ack   = extra_dack | (dmem_req & (d_cnt == dmem_wait));
    assign imem_rdata = prog[prog_idx];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt    <= 0;
            d_cnt    <= 0;
            prog_idx <= 0;
        end else begin
            i_cnt <= (imem_req && !imem_ack) ? i_cnt + 1 : 0;
            d_cnt <= (dmem_req && !dmem_ack) ? d_cnt + 1 : 0;
            if (imem_req && imem_ack && prog_idx < prog_len - 1) prog_idx <= prog_idx + 1;
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        logic [31:0] ir;
        logic        trap;
        logic [1:0]  cause;
        int          lat;
        int          ireq;
        int          dreq;
        int          dwe;
        int          rfwe;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] e_pc, input logic [31:0] e_ret, input logic [31:0] e_ir,
                        input logic e_trap, input logic [1:0] e_cause, input int e_lat,
                        input int e_ireq, input int e_dreq, input int e_dwe, input int e_rfwe);
        exp_t e;
        e.pc = e_pc; e.instret = e_ret; e.ir = e_ir; e.trap = e_trap; e.cause = e_cause;
        e.lat = e_lat; e.ireq = e_ireq; e.dreq = e_dreq; e.dwe = e_dwe; e.rfwe = e_rfwe;
        sb.push_back(e);
    endtask

    // Monitor: samples 1 ns before each rising edge; an event is a retirement
    // or entry into trap, and strobe counts accumulate between events.
    logic [31:0] m_prev_ret;
    logic        m_prev_trap;
    int          m_lat, m_ireq, m_dreq, m_dwe, m_rfwe;

    initial begin
        exp_t e;
        m_prev_ret = 0; m_prev_trap = 0;
        m_lat = 0; m_ireq = 0; m_dreq = 0; m_dwe = 0; m_rfwe = 0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                m_prev_ret = 0; m_prev_trap = 0;
                m_lat = 0; m_ireq = 0; m_dreq = 0; m_dwe = 0; m_rfwe = 0;
            end else begin
                if (instret !== m_prev_ret || (trap && !m_prev_trap)) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: pc=%h instret=%h trap=%b", pc, instret, trap);
                    end else begin
                        e = sb.pop_front();
                        chk("pc", pc, e.pc);
                        chk("instret", instret, e.instret);
                        chk("ir", ir, e.ir);
                        chk("trap", {31'd0, trap}, {31'd0, e.trap});
                        chk("trap_cause", {30'd0, trap_cause}, {30'd0, e.cause});
                        chk("latency", m_lat, e.lat);
                        chk("imem_req_cycles", m_ireq, e.ireq);
                        chk("dmem_req_cycles", m_dreq, e.dreq);
                        chk("dmem_we_cycles", m_dwe, e.dwe);
                        chk("rf_we_cycles", m_rfwe, e.rfwe);
                    end
                    m_prev_ret = instret; m_prev_trap = trap;
                    m_lat = 0; m_ireq = 0; m_dreq = 0; m_dwe = 0; m_rfwe = 0;
                end
                if (trap) chk("trap_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 32'd0);
                m_lat++;
                m_ireq += int'(imem_req);
                m_dreq += int'(dmem_req);
                m_dwe  += int'(dmem_we);
                m_rfwe += int'(rf_we);
            end
        end
    end

    task automatic enter_reset(input logic [31:0] p0, input logic [31:0] p1, input int plen,
                               input int iw, input int dw, input logic inever,
                               input logic xi, input logic xd, input logic bt, input logic [31:0] tg);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        prog[0] = p0; prog[1] = p1; prog_len = plen;
        imem_wait = iw; dmem_wait = dw; imem_never = inever;
        extra_iack = xi; extra_dack = xd; branch_taken = bt; target = tg;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int hold);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: %0d events outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        int n;
        prog[0] = c_ADDI; prog[1] = c_ADDI;
        branch_taken = 1'b0; target = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_pc", pc, 32'd0);
        chk("reset_ir", ir, 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_trap", {29'd0, trap, trap_cause}, 32'd0);
        chk("reset_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 32'd0);

        // ADDI zero-wait, two back-to-back retirements
        enter_reset(c_ADDI, c_ADDI, 1, 0, 0, 0, 0, 0, 0, 32'd0);
        push(32'd4, 1, c_ADDI, 0, 2'b00, 4, 1, 0, 0, 1);
        push(32'd8, 2, c_ADDI, 0, 2'b00, 4, 1, 0, 0, 1);
        release_reset(); wait_done(0);

        // Load with 3 wait cycles; imem_ack held high outside FETCH
        enter_reset(c_LW, c_LW, 1, 0, 3, 0, 1, 0, 0, 32'd0);
        push(32'd4, 1, c_LW, 0, 2'b00, 8, 1, 4, 0, 1);
        release_reset(); wait_done(0);

        // Store zero-wait; dmem_ack held high outside MEM
        enter_reset(c_SW, c_SW, 1, 0, 0, 0, 0, 1, 0, 32'd0);
        push(32'd4, 1, c_SW, 0, 2'b00, 4, 1, 1, 1, 0);
        release_reset(); wait_done(0);

        // Taken branch to 0x40
        enter_reset(c_BEQ, c_BEQ, 1, 0, 0, 0, 0, 0, 1, 32'h40);
        push(32'h40, 1, c_BEQ, 0, 2'b00, 3, 1, 0, 0, 0);
        push(32'h40, 2, c_BEQ, 0, 2'b00, 3, 1, 0, 0, 0);
        release_reset(); wait_done(0);

        // Not-taken branch
        enter_reset(c_BEQ, c_BEQ, 1, 0, 0, 0, 0, 0, 0, 32'h40);
        push(32'd4, 1, c_BEQ, 0, 2'b00, 3, 1, 0, 0, 0);
        push(32'd8, 2, c_BEQ, 0, 2'b00, 3, 1, 0, 0, 0);
        release_reset(); wait_done(0);

        // Taken branch to misaligned 0x42
        enter_reset(c_BEQ, c_BEQ, 1, 0, 0, 0, 0, 0, 1, 32'h42);
        push(32'd0, 0, c_BEQ, 1, 2'b11, 3, 1, 0, 0, 0);
        release_reset(); wait_done(8);

        // FENCE is illegal here
        enter_reset(c_FENCE, c_FENCE, 1, 0, 0, 0, 0, 0, 0, 32'd0);
        push(32'd0, 0, 32'd0, 1, 2'b01, 1, 1, 0, 0, 0);
        release_reset(); wait_done(8);

        // All-zero word fails on bits[1:0]
        enter_reset(32'd0, 32'd0, 1, 0, 0, 0, 0, 0, 0, 32'd0);
        push(32'd0, 0, 32'd0, 1, 2'b01, 1, 1, 0, 0, 0);
        release_reset(); wait_done(8);

        // Fetch never acked: timeout after 16 request cycles
        enter_reset(c_ADDI, c_ADDI, 1, 0, 0, 1, 0, 0, 0, 32'd0);
        push(32'd0, 0, 32'd0, 1, 2'b10, 16, 16, 0, 0, 0);
        release_reset(); wait_done(5);

        // Ack on exactly the 16th request cycle wins over the timeout
        enter_reset(c_ADDI, c_ADDI, 1, 15, 0, 0, 0, 0, 0, 32'd0);
        push(32'd4, 1, c_ADDI, 0, 2'b00, 19, 16, 0, 0, 1);
        release_reset(); wait_done(0);

        // JAL to 0xFFFF_FFFC then ADDI there: pc wraps to 0
        enter_reset(c_JAL, c_ADDI, 2, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 1, c_JAL, 0, 2'b00, 4, 1, 0, 0, 1);
        push(32'd0, 2, c_ADDI, 0, 2'b00, 4, 1, 0, 0, 1);
        release_reset(); wait_done(0);

        // Reset asserted mid data access
        enter_reset(c_ADDI, c_LW, 2, 0, 10, 0, 0, 0, 0, 32'd0);
        push(32'd4, 1, c_ADDI, 0, 2'b00, 4, 1, 0, 0, 1);
        release_reset(); wait_done(0);
        n = 0;
        while (!dmem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_dmem_req_before", {31'd0, dmem_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("midreset_pc", pc, 32'd0);
        chk("midreset_instret", instret, 32'd0);
        push(32'd4, 1, c_ADDI, 0, 2'b00, 4, 1, 0, 0, 1);
        release_reset(); wait_done(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
